// File: rtl/sample_serializer.sv
// Mono-to-I2S serializer: a small sample FIFO feeds 32-slot stereo frames,
// with the same 16-bit sample sent on the left and right channels.
module sample_serializer #(
  parameter int CLOCK_DIV  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_SampleReady,
  input  logic [15:0] i_Sample,
  output logic        o_BitClock,
  output logic        o_WordSelect,
  output logic        o_SerialData,
  output logic        o_Overflow,
  output logic        o_Underflow,
  output logic [4:0]  o_FifoLevel
);

  localparam int         AddrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] DivLast  = 8'(CLOCK_DIV - 1);
  localparam logic [4:0] DepthLvl = 5'(FIFO_DEPTH);

  logic [7:0]       divCnt_q, divCnt_d;
  logic             bitClk_q, bitClk_d;
  logic [4:0]       slot_q, slot_d;
  logic [15:0]      frame_q, frame_d;
  logic             ws_q, ws_d;
  logic             data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [AddrW-1:0] wrPtr_q, wrPtr_d;
  logic [AddrW-1:0] rdPtr_q, rdPtr_d;
  logic [4:0]       level_q, level_d;
  logic [15:0]      mem [FIFO_DEPTH];

  logic divWrap;
  logic fallEvt;
  logic popReq;
  logic popDo;
  logic pushDo;
  logic fifoEmpty;
  logic fifoFull;

  // Next-state logic: bit-clock divider, slot sequencing on falling events,
  // frame load at the slot 31->0 wrap, and FIFO bookkeeping.
  always_comb begin
    divCnt_d = divCnt_q;
    bitClk_d = bitClk_q;
    slot_d   = slot_q;
    frame_d  = frame_q;
    ws_d     = ws_q;
    data_d   = data_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    level_d  = level_q;

    divWrap   = (divCnt_q == DivLast);
    fallEvt   = divWrap & bitClk_q;
    popReq    = fallEvt & (slot_q == 5'd31);
    fifoEmpty = (level_q == 5'd0);
    fifoFull  = (level_q == DepthLvl);
    popDo     = popReq & ~fifoEmpty;
    // A pop in the same cycle frees the slot the push needs, so a full FIFO
    // can still accept a sample on the frame boundary.
    pushDo    = i_SampleReady & (~fifoFull | popDo);
    unf_d     = popReq & fifoEmpty;
    ovf_d     = i_SampleReady & fifoFull & ~popDo;

    if (divWrap) begin
      divCnt_d = 8'd0;
      bitClk_d = ~bitClk_q;
    end else begin
      divCnt_d = divCnt_q + 8'd1;
    end

    if (fallEvt) begin
      slot_d = slot_q + 5'd1;
      if (popReq) begin
        frame_d = popDo ? mem[rdPtr_q] : 16'h0000;
      end
      // WS changes one slot ahead of the data, as I2S expects.
      data_d = frame_d[4'd15 - slot_d[3:0]];
      ws_d   = (slot_d >= 5'd15) && (slot_d <= 5'd30);
    end

    if (pushDo) begin
      wrPtr_d = wrPtr_q + AddrW'(1);
    end
    if (popDo) begin
      rdPtr_d = rdPtr_q + AddrW'(1);
    end
    case ({pushDo, popDo})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  // State registers; reset discards any queued samples and the frame in flight.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      divCnt_q <= 8'd0;
      bitClk_q <= 1'b0;
      slot_q   <= 5'd31;
      frame_q  <= 16'h0000;
      ws_q     <= 1'b0;
      data_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      level_q  <= 5'd0;
    end else begin
      divCnt_q <= divCnt_d;
      bitClk_q <= bitClk_d;
      slot_q   <= slot_d;
      frame_q  <= frame_d;
      ws_q     <= ws_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage; stale entries are harmless because the pointers gate reads.
  always_ff @(posedge i_Clock) begin
    if (pushDo) begin
      mem[wrPtr_q] <= i_Sample;
    end
  end

  assign o_BitClock   = bitClk_q;
  assign o_WordSelect = ws_q;
  assign o_SerialData = data_q;
  assign o_Overflow   = ovf_q;
  assign o_Underflow  = unf_q;
  assign o_FifoLevel  = level_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Self-checking bench for sample_serializer: a queue-based frame model
// predicts every output after every clock edge.
module tb_sample_serializer;

  localparam int ClockDiv  = 2;
  localparam int FifoDepth = 4;
  localparam int BitPeriod = 2 * ClockDiv;

  logic        clock = 1'b0;
  logic        resetN;
  logic        sampleReady;
  logic [15:0] sample;
  logic        bitClock;
  logic        wordSelect;
  logic        serialData;
  logic        overflow;
  logic        underflow;
  logic [4:0]  fifoLevel;

  int assertCount = 0;
  int failCount   = 0;

  // Model state
  int          edgeCnt;
  int          expSlot;
  logic [15:0] q[$];
  logic [15:0] frameSample;
  logic        expBitClk;
  logic        expWs;
  logic        expData;
  logic        expOvf;
  logic        expUnf;

  always #5 clock = ~clock;

  sample_serializer #(
    .CLOCK_DIV (ClockDiv),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .i_Clock      (clock),
    .i_Reset_n    (resetN),
    .i_SampleReady(sampleReady),
    .i_Sample     (sample),
    .o_BitClock   (bitClock),
    .o_WordSelect (wordSelect),
    .o_SerialData (serialData),
    .o_Overflow   (overflow),
    .o_Underflow  (underflow),
    .o_FifoLevel  (fifoLevel)
  );

  task automatic checkOne(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("bitClock",   16'(bitClock),   16'(expBitClk));
    checkOne("wordSelect", 16'(wordSelect), 16'(expWs));
    checkOne("serialData", 16'(serialData), 16'(expData));
    checkOne("overflow",   16'(overflow),   16'(expOvf));
    checkOne("underflow",  16'(underflow),  16'(expUnf));
    checkOne("fifoLevel",  16'(fifoLevel),  16'(q.size()));
  endtask

  task automatic modelReset();
    edgeCnt     = 0;
    expSlot     = 31;
    q.delete();
    frameSample = 16'h0000;
    expBitClk   = 1'b0;
    expWs       = 1'b0;
    expData     = 1'b0;
    expOvf      = 1'b0;
    expUnf      = 1'b0;
  endtask

  // One rising edge of the system clock as seen from the outside: bit clock
  // phase follows from elapsed edges, slots from elapsed bit periods.
  task automatic modelStep(input logic push, input logic [15:0] smp);
    bit fall;
    bit popNow;
    bit wasFull;
    edgeCnt++;
    expBitClk = 1'((edgeCnt / ClockDiv) % 2);
    fall      = (edgeCnt % BitPeriod) == 0;
    popNow    = fall && (((edgeCnt / BitPeriod) - 1) % 32 == 0);
    wasFull   = (q.size() == FifoDepth);
    expOvf    = 1'b0;
    expUnf    = 1'b0;
    if (popNow) begin
      if (q.size() > 0) begin
        frameSample = q.pop_front();
      end else begin
        frameSample = 16'h0000;
        expUnf      = 1'b1;
      end
    end
    if (push) begin
      if (!wasFull || popNow) q.push_back(smp);
      else expOvf = 1'b1;
    end
    if (fall) begin
      expSlot = ((edgeCnt / BitPeriod) - 1) % 32;
      expData = frameSample[15 - (expSlot % 16)];
      expWs   = (expSlot >= 15) && (expSlot <= 30);
    end
  endtask

  task automatic applyStimulus(input logic push, input logic [15:0] smp);
    sampleReady = push;
    sample      = push ? smp : 16'($urandom);
    @(posedge clock);
    modelStep(push, smp);
    #1;
    checkOutput();
    sampleReady = 1'b0;
  endtask

  function automatic bit nextIsWrap();
    int n;
    n = edgeCnt + 1;
    return (n % BitPeriod == 0) && (((n / BitPeriod) - 1) % 32 == 0);
  endfunction

  task automatic advanceToWrap();
    for (int i = 0; i < 300; i++) begin
      if (nextIsWrap()) break;
      applyStimulus(1'b0, 16'h0000);
    end
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000);
  endtask

  task automatic drainFifo();
    for (int i = 0; i < 1200; i++) begin
      if (q.size() == 0) break;
      applyStimulus(1'b0, 16'h0000);
    end
    checkOne("drainDone", 16'(q.size()), 16'd0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic doReset();
    resetN      = 1'b0;
    sampleReady = 1'b0;
    modelReset();
    #1;
    checkOutput();
    repeat (2) begin
      @(posedge clock);
      #1;
      checkOutput();
    end
    @(negedge clock);
    resetN = 1'b1;
  endtask

  initial begin
    resetN      = 1'b0;
    sampleReady = 1'b0;
    sample      = 16'h0000;
    modelReset();

    // Idle frames after reset: underflow each frame, zero data
    doReset();
    runIdle(140);

    // Single sample loaded before the first frame
    doReset();
    applyStimulus(1'b1, 16'hA5C3);
    runIdle(130);

    // Five back-to-back pushes, the last one overflows
    advanceToWrap();
    applyStimulus(1'b0, 16'h0000);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 16'(i));
    runIdle(5 * 128 + 10);

    // Full FIFO with a push on the pop edge
    advanceToWrap();
    applyStimulus(1'b0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      if (q.size() == FifoDepth) break;
      applyStimulus(1'b1, 16'($urandom));
    end
    checkOne("filledFull", 16'(fifoLevel), 16'(FifoDepth));
    advanceToWrap();
    applyStimulus(1'b1, 16'h7FFF);
    runIdle(20);

    // Empty FIFO with a push on the pop edge
    drainFifo();
    advanceToWrap();
    applyStimulus(1'b1, 16'h8000);
    runIdle(2 * 128 + 10);

    // Random traffic including bursts and overflow
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 99) < 3) applyStimulus(1'b1, 16'($urandom));
      else applyStimulus(1'b0, 16'h0000);
    end

    // Reset in the middle of the right word with three samples queued
    drainFifo();
    advanceToWrap();
    applyStimulus(1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'($urandom));
    for (int i = 0; i < 300; i++) begin
      if (expSlot == 20) break;
      applyStimulus(1'b0, 16'h0000);
    end
    checkOne("slot20Reached", 16'(expSlot), 16'd20);
    checkOne("levelBeforeReset", 16'(fifoLevel), 16'd3);
    doReset();
    runIdle(140);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sample_serializer.md
SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 SHALL have parameter CLOCK_DIV, default 4: system clocks per bit-clock half-period; legal range 1..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: sample FIFO entries; power of two, 2..16.
REQ-003 i_Clock  input  1  system clock; all state updates on its rising edge.
REQ-004 i_Reset_n  input  1  reset, asynchronous and active-low.
REQ-005 i_SampleReady  input  1  one-cycle pulse: i_Sample is valid this cycle.
REQ-006 i_Sample  input  16  signed two's-complement mono sample.
REQ-007 o_BitClock  output  1  serial bit clock (I2S SCK).
REQ-008 o_WordSelect  output  1  channel select (I2S WS): 0 = left, 1 = right.
REQ-009 o_SerialData  output  1  serial data, MSB first.
REQ-010 o_Overflow  output  1  one-cycle pulse: a sample was dropped because the FIFO was full.
REQ-011 o_Underflow  output  1  one-cycle pulse: a frame started with the FIFO empty.
REQ-012 o_FifoLevel  output  5  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-013 SHALL keep a divider counter 0..CLOCK_DIV-1; when it reaches CLOCK_DIV-1 it wraps to 0 and o_BitClock toggles on the same edge.
REQ-014 A "falling event" SHALL be the cycle in which o_BitClock toggles from 1 to 0; all slot, WS and data updates occur only on falling events.
REQ-015 SHALL keep slot index s, 0..31, incremented modulo 32 on each falling event.
REQ-016 Frame SHALL be 32 slots: s 0..15 carry the left word, s 16..31 carry the right word; both words equal the same mono sample.
REQ-017 o_SerialData SHALL equal bit (15 - (s mod 16)) of the current frame sample, registered on the falling event that sets s.
REQ-018 o_WordSelect SHALL lead data by one slot (I2S): 1 for s in 15..30, 0 for s in 31 and 0..14.
REQ-019 On the falling event where s wraps 31->0, SHALL pop the FIFO head into the frame register if o_FifoLevel != 0; otherwise SHALL load 16'h0000 and pulse o_Underflow for that cycle.
REQ-020 FIFO write: on i_SampleReady with FIFO not full, SHALL store i_Sample at the tail; o_FifoLevel updates on the next edge.
REQ-021 On i_SampleReady with FIFO full and no pop in the same cycle, SHALL drop i_Sample, leave contents unchanged, and pulse o_Overflow.
REQ-022 Simultaneous push and pop with FIFO full: pop SHALL take the head, push SHALL be accepted, level unchanged, no o_Overflow.
REQ-023 Simultaneous push and pop with FIFO empty: pop SHALL underflow per REQ-019, push SHALL be accepted (no bypass), level becomes 1.
REQ-024 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; samples SHALL leave in arrival order.
REQ-025 i_Sample SHALL be ignored whenever i_SampleReady is 0.
REQ-026 o_Overflow and o_Underflow SHALL be registered and high for exactly one i_Clock cycle per event.

Reset
REQ-027 While i_Reset_n = 0: o_BitClock, o_WordSelect, o_SerialData, o_Overflow, o_Underflow = 0; o_FifoLevel = 0; divider = 0; s = 31; frame register = 0; FIFO pointers = 0.
REQ-028 Assertion of i_Reset_n mid-frame SHALL discard all FIFO contents and the in-flight frame immediately (asynchronous).
REQ-029 After release, first o_BitClock rise SHALL occur CLOCK_DIV edges later, first falling event at 2*CLOCK_DIV edges, which starts slot 0 per REQ-019.

Verification (CLOCK_DIV = 2, FIFO_DEPTH = 4 unless stated)
REQ-030 Reset release, no samples -> o_BitClock period 4 clocks; first falling event at edge 4 with o_Underflow pulse; o_SerialData stays 0; o_WordSelect high for slots 15..30, repeating every 128 clocks.
REQ-031 Push 16'hA5C3 before first falling event -> slots 0..15 and 16..31 each shift 1010010111000011 MSB first; o_WordSelect rises one slot before bit 15 of left ends; o_FifoLevel 1->0 at slot 0.
REQ-032 Push 5 samples 16'h0001..16'h0005 back-to-back with no pop -> o_FifoLevel reaches 4; o_Overflow pulses once on the 5th; frames output 0001,0002,0003,0004 then underflow zeros.
REQ-033 FIFO full, push 16'h7FFF in the cycle s wraps 31->0 -> head popped, 7FFF accepted, level stays 4, no o_Overflow.
REQ-034 FIFO empty, push 16'h8000 in the wrap cycle -> o_Underflow pulses, that frame all zeros, next frame outputs 8000.
REQ-035 Assert i_Reset_n low at slot 20 with level 3 -> all outputs 0 and level 0 within the same cycle; after release REQ-030 behaviour, no stale samples emitted.
